// File: rtl/csi_tx_clk_lane.sv
// MIPI D-PHY clock-lane transmitter sequencer.
// Walks the lane from LP-11 STOP through the HS-request / bridge / HS-0
// preamble into a continuously toggling HS clock. On shutdown it runs the
// post / trail / exit sequence back to STOP. Every output is a flop that is
// loaded from the decode of the next state. The outputs therefore change on
// the same edge as the state register, and no combinational path reaches a pin.
//
// Handshake: hs_req is a level, not a valid/ready pair. A rising hs_req is
// accepted only while the lane sits in STOP. hs_ready answers with a level
// that is high only while the clock is free-running in HS_ACTIVE. A falling
// hs_req is honoured only in HS_ACTIVE (or at the end of CLK_PRE). Every
// other state runs to completion regardless of hs_req.
module csi_tx_clk_lane #(
  parameter int T_LPX         = 2,
  parameter int T_CLK_PREPARE = 2,
  parameter int T_CLK_ZERO    = 8,
  parameter int T_CLK_PRE     = 2,
  parameter int T_CLK_POST    = 8,
  parameter int T_CLK_TRAIL   = 2,
  parameter int T_HS_EXIT     = 3
) (
  input  logic       byte_clock,
  input  logic       reset,
  input  logic       hs_req,
  output logic       lp_p,
  output logic       lp_n,
  output logic       hs_en,
  output logic [7:0] hs_byte,
  output logic       hs_ready,
  output logic       stop_state,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    ST_STOP      = 4'd0,
    ST_HS_RQST   = 4'd1,
    ST_BRIDGE    = 4'd2,
    ST_CLK_ZERO  = 4'd3,
    ST_CLK_PRE   = 4'd4,
    ST_HS_ACTIVE = 4'd5,
    ST_CLK_POST  = 4'd6,
    ST_TRAIL     = 4'd7,
    ST_HS_EXIT   = 4'd8
  } state_t;

  // The down-counter is loaded with duration-1 on entry. The state exits on
  // the edge where the counter reads 0, so a state lasts exactly its duration.
  localparam logic [7:0] LPX_LD   = 8'(T_LPX - 1);
  localparam logic [7:0] PREP_LD  = 8'(T_CLK_PREPARE - 1);
  localparam logic [7:0] ZERO_LD  = 8'(T_CLK_ZERO - 1);
  localparam logic [7:0] PRE_LD   = 8'(T_CLK_PRE - 1);
  localparam logic [7:0] POST_LD  = 8'(T_CLK_POST - 1);
  localparam logic [7:0] TRAIL_LD = 8'(T_CLK_TRAIL - 1);
  localparam logic [7:0] EXIT_LD  = 8'(T_HS_EXIT - 1);

  // 0101_0101: the serializer sends the LSB first, so the wire sees 1,0,1,0...
  // The byte is constant, so the toggle phase is continuous across
  // CLK_PRE, HS_ACTIVE and CLK_POST.
  localparam logic [7:0] CLK_PATTERN = 8'h55;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic       lp_p_q, lp_p_d;
  logic       lp_n_q, lp_n_d;
  logic       hs_en_q, hs_en_d;
  logic [7:0] hs_byte_q, hs_byte_d;
  logic       hs_ready_q, hs_ready_d;
  logic       stop_state_q, stop_state_d;

  // Next-state and dwell-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_STOP: begin
        cnt_d = 8'd0;
        if (hs_req) begin
          state_d = ST_HS_RQST;
          cnt_d   = LPX_LD;
        end
      end
      ST_HS_RQST: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_BRIDGE;
          cnt_d   = PREP_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_BRIDGE: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_CLK_ZERO;
          cnt_d   = ZERO_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_CLK_ZERO: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_CLK_PRE;
          cnt_d   = PRE_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_CLK_PRE: begin
        // A request that dropped during startup skips HS_ACTIVE entirely.
        if (cnt_q == 8'd0) begin
          if (hs_req) begin
            state_d = ST_HS_ACTIVE;
            cnt_d   = 8'd0;
          end else begin
            state_d = ST_CLK_POST;
            cnt_d   = POST_LD;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HS_ACTIVE: begin
        cnt_d = 8'd0;
        if (!hs_req) begin
          state_d = ST_CLK_POST;
          cnt_d   = POST_LD;
        end
      end
      ST_CLK_POST: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_TRAIL;
          cnt_d   = TRAIL_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_TRAIL: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_HS_EXIT;
          cnt_d   = EXIT_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HS_EXIT: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_STOP;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_STOP;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Moore output decode of the state being entered, so the output flops
  // change in lockstep with the state register.
  always_comb begin
    lp_p_d       = 1'b0;
    lp_n_d       = 1'b0;
    hs_en_d      = 1'b0;
    hs_byte_d    = 8'h00;
    hs_ready_d   = 1'b0;
    stop_state_d = 1'b0;
    unique case (state_d)
      ST_STOP: begin
        lp_p_d       = 1'b1;
        lp_n_d       = 1'b1;
        stop_state_d = 1'b1;
      end
      ST_HS_RQST: begin
        lp_n_d = 1'b1;
      end
      ST_BRIDGE: begin
      end
      ST_CLK_ZERO, ST_TRAIL: begin
        hs_en_d = 1'b1;
      end
      ST_CLK_PRE, ST_CLK_POST: begin
        hs_en_d   = 1'b1;
        hs_byte_d = CLK_PATTERN;
      end
      ST_HS_ACTIVE: begin
        hs_en_d    = 1'b1;
        hs_byte_d  = CLK_PATTERN;
        hs_ready_d = 1'b1;
      end
      ST_HS_EXIT: begin
        lp_p_d = 1'b1;
        lp_n_d = 1'b1;
      end
      default: begin
        lp_p_d = 1'b1;
        lp_n_d = 1'b1;
      end
    endcase
  end

  // State, counter and output registers. Reset forces LP-11 STOP
  // immediately, even mid-HS, with no trail.
  always_ff @(posedge byte_clock) begin
    if (reset) begin
      state_q      <= ST_STOP;
      cnt_q        <= 8'd0;
      lp_p_q       <= 1'b1;
      lp_n_q       <= 1'b1;
      hs_en_q      <= 1'b0;
      hs_byte_q    <= 8'h00;
      hs_ready_q   <= 1'b0;
      stop_state_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lp_p_q       <= lp_p_d;
      lp_n_q       <= lp_n_d;
      hs_en_q      <= hs_en_d;
      hs_byte_q    <= hs_byte_d;
      hs_ready_q   <= hs_ready_d;
      stop_state_q <= stop_state_d;
    end
  end

  assign lp_p       = lp_p_q;
  assign lp_n       = lp_n_q;
  assign hs_en      = hs_en_q;
  assign hs_byte    = hs_byte_q;
  assign hs_ready   = hs_ready_q;
  assign stop_state = stop_state_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_csi_tx_clk_lane.sv
// Directed bench for csi_tx_clk_lane. One instance uses the default timing
// and a second instance has every duration set to 1. Outputs are sampled
// 1 ns after each rising edge. The expected output words are written out
// by hand from the lane timing.
module tb_csi_tx_clk_lane;

  logic clk;
  logic rst0, req0, rst1, req1;

  logic       lp_p0, lp_n0, hs_en0, hs_ready0, stop_state0;
  logic [7:0] hs_byte0;
  logic [3:0] state_dbg0;
  logic       lp_p1, lp_n1, hs_en1, hs_ready1, stop_state1;
  logic [7:0] hs_byte1;
  logic [3:0] state_dbg1;

  int n_checks = 0;
  int n_fail   = 0;

  // Observed word: {lp_p, lp_n, hs_en, hs_ready, stop_state, hs_byte}
  logic [12:0] obs0, obs1;
  assign obs0 = {lp_p0, lp_n0, hs_en0, hs_ready0, stop_state0, hs_byte0};
  assign obs1 = {lp_p1, lp_n1, hs_en1, hs_ready1, stop_state1, hs_byte1};

  localparam logic [12:0] O_STOP   = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
  localparam logic [12:0] O_RQST   = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
  localparam logic [12:0] O_BRIDGE = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
  localparam logic [12:0] O_ZERO   = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
  localparam logic [12:0] O_TOG    = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55};
  localparam logic [12:0] O_ACT    = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55};
  localparam logic [12:0] O_EXIT   = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

  csi_tx_clk_lane dut (
    .byte_clock(clk), .reset(rst0), .hs_req(req0),
    .lp_p(lp_p0), .lp_n(lp_n0), .hs_en(hs_en0), .hs_byte(hs_byte0),
    .hs_ready(hs_ready0), .stop_state(stop_state0), .state_dbg(state_dbg0)
  );

  csi_tx_clk_lane #(
    .T_LPX(1), .T_CLK_PREPARE(1), .T_CLK_ZERO(1), .T_CLK_PRE(1),
    .T_CLK_POST(1), .T_CLK_TRAIL(1), .T_HS_EXIT(1)
  ) dut1 (
    .byte_clock(clk), .reset(rst1), .hs_req(req1),
    .lp_p(lp_p1), .lp_n(lp_n1), .hs_en(hs_en1), .hs_byte(hs_byte1),
    .hs_ready(hs_ready1), .stop_state(stop_state1), .state_dbg(state_dbg1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1; req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs0 !== O_STOP) begin
        n_fail++;
        $display("FAIL reset_dut0 edge %0d: got %h expected %h", i, obs0, O_STOP);
      end
      n_checks++;
      if (obs1 !== O_STOP) begin
        n_fail++;
        $display("FAIL reset_dut1 edge %0d: got %h expected %h", i, obs1, O_STOP);
      end
    end
    rst0 = 1'b0; rst1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs0 !== O_STOP || obs1 !== O_STOP) begin
        n_fail++;
        $display("FAIL idle_stop edge %0d: got %h/%h expected %h", i, obs0, obs1, O_STOP);
      end
    end
  endtask

  // Request rises at edge 0 and is held; lane ends in HS_ACTIVE.
  task automatic test_startup();
    logic [12:0] exp;
    req0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i < 2)       exp = O_RQST;
      else if (i < 4)  exp = O_BRIDGE;
      else if (i < 12) exp = O_ZERO;
      else if (i < 14) exp = O_TOG;
      else             exp = O_ACT;
      n_checks++;
      if (obs0 !== exp) begin
        n_fail++;
        $display("FAIL startup edge %0d: got %h expected %h", i, obs0, exp);
      end
    end
  endtask

  // Request drops in HS_ACTIVE at edge 0; full shutdown to STOP.
  task automatic test_shutdown();
    logic [12:0] exp;
    req0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i < 8)       exp = O_TOG;
      else if (i < 10) exp = O_ZERO;
      else if (i < 13) exp = O_EXIT;
      else             exp = O_STOP;
      n_checks++;
      if (obs0 !== exp) begin
        n_fail++;
        $display("FAIL shutdown edge %0d: got %h expected %h", i, obs0, exp);
      end
    end
  endtask

  // One-cycle request: startup completes, CLK_PRE goes straight to CLK_POST.
  task automatic test_pulse();
    logic [12:0] exp;
    for (int i = 0; i < 30; i++) begin
      req0 = (i == 0);
      tick();
      if (i < 2)       exp = O_RQST;
      else if (i < 4)  exp = O_BRIDGE;
      else if (i < 12) exp = O_ZERO;
      else if (i < 22) exp = O_TOG;
      else if (i < 24) exp = O_ZERO;
      else if (i < 27) exp = O_EXIT;
      else             exp = O_STOP;
      n_checks++;
      if (obs0 !== exp) begin
        n_fail++;
        $display("FAIL pulse edge %0d: got %h expected %h", i, obs0, exp);
      end
    end
  endtask

  // One-cycle reset in HS_ACTIVE, then the held request restarts the lane.
  task automatic test_reset_mid_hs();
    logic [12:0] exp;
    req0 = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    n_checks++;
    if (obs0 !== O_ACT) begin
      n_fail++;
      $display("FAIL pre_reset_active: got %h expected %h", obs0, O_ACT);
    end
    rst0 = 1'b1;
    tick();
    n_checks++;
    if (obs0 !== O_STOP) begin
      n_fail++;
      $display("FAIL reset_mid_hs: got %h expected %h", obs0, O_STOP);
    end
    rst0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i < 2)       exp = O_RQST;
      else if (i < 4)  exp = O_BRIDGE;
      else if (i < 12) exp = O_ZERO;
      else if (i < 14) exp = O_TOG;
      else             exp = O_ACT;
      n_checks++;
      if (obs0 !== exp) begin
        n_fail++;
        $display("FAIL restart edge %0d: got %h expected %h", i, obs0, exp);
      end
    end
  endtask

  // Request re-asserted during TRAIL is ignored until one cycle after STOP.
  task automatic test_trail_reassert();
    logic [12:0] exp;
    for (int i = 0; i < 16; i++) begin
      req0 = (i >= 8);
      tick();
      if (i < 8)       exp = O_TOG;
      else if (i < 10) exp = O_ZERO;
      else if (i < 13) exp = O_EXIT;
      else if (i < 14) exp = O_STOP;
      else             exp = O_RQST;
      n_checks++;
      if (obs0 !== exp) begin
        n_fail++;
        $display("FAIL trail_reassert edge %0d: got %h expected %h", i, obs0, exp);
      end
    end
  endtask

  // Reset held with the request high: the first edge with reset low accepts it.
  task automatic test_reset_held_req();
    logic [12:0] exp;
    rst0 = 1'b1; req0 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (obs0 !== O_STOP) begin
        n_fail++;
        $display("FAIL reset_held_req edge %0d: got %h expected %h", i, obs0, O_STOP);
      end
    end
    rst0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = (i < 2) ? O_RQST : O_BRIDGE;
      n_checks++;
      if (obs0 !== exp) begin
        n_fail++;
        $display("FAIL release_req edge %0d: got %h expected %h", i, obs0, exp);
      end
    end
  endtask

  // All durations 1: hs_ready at edge 4, then a minimal shutdown with re-request.
  task automatic test_min_params();
    logic [12:0] exp;
    req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      case (i)
        0:       exp = O_RQST;
        1:       exp = O_BRIDGE;
        2:       exp = O_ZERO;
        3:       exp = O_TOG;
        default: exp = O_ACT;
      endcase
      n_checks++;
      if (obs1 !== exp) begin
        n_fail++;
        $display("FAIL min_startup edge %0d: got %h expected %h", i, obs1, exp);
      end
    end
    for (int i = 0; i < 6; i++) begin
      req1 = (i != 0);
      tick();
      case (i)
        0:       exp = O_TOG;
        1:       exp = O_ZERO;
        2:       exp = O_EXIT;
        3:       exp = O_STOP;
        default: exp = O_RQST;
      endcase
      if (i == 5) exp = O_BRIDGE;
      n_checks++;
      if (obs1 !== exp) begin
        n_fail++;
        $display("FAIL min_shutdown edge %0d: got %h expected %h", i, obs1, exp);
      end
    end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; req0 = 1'b0; req1 = 1'b0;
    test_reset();
    test_startup();
    test_shutdown();
    test_pulse();
    test_reset_mid_hs();
    test_trail_reassert();
    test_reset_held_req();
    test_min_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
